scratchpad_mem_server: RTL and testbench

- Memory-side responder for the kernel wrapper's single-word request bus (read_enable/read_addr/read_ready/read_data, write_enable/write_addr/write_data/write_ready).
- Services each request from an on-chip word array after a programmable latency, then returns a one-cycle ready pulse.
- Keeps access counters and a sticky error flag for the verification harness.
- Provides a host preload port to initialise the array before the kernel starts.

---
 rtl/scratchpad_mem_pkg.sv | 22 ++
 rtl/spm_word_ram.sv | 25 ++
 rtl/scratchpad_mem_server.sv | 201 ++++++++++++++++++++
 tb/tb_scratchpad_mem_server.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scratchpad_mem_pkg.sv
// Shared types and constants for the scratchpad memory server.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scratchpad_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_RESP,
        ST_WR_WAIT,
        ST_WR_RESP
    } spm_state_t;

    // Ready outputs are 64 bits wide on the kernel bus; only bit 0 ever toggles.
    localparam logic [63:0] RDY_ON     = 64'd1;
    localparam logic [63:0] RDY_OFF    = 64'd0;
    localparam logic [63:0] WORD_BYTES = 64'd4;

    // Latency counter width; both latencies are limited to 1..15.
    localparam int LAT_WID = 4;

endpackage

// File: rtl/spm_word_ram.sv
// Single-port synchronous word RAM, read-before-write on the shared port.
// Latency: read data valid one cycle after the address is presented.
// Backpressure: none; accepts one access every cycle.
module spm_word_ram #(
    parameter int unsigned ADDR_WID = 13,
    parameter int unsigned DATA_WID = 32
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_WID-1:0] addr,
    input  logic [DATA_WID-1:0] wdata,
    output logic [DATA_WID-1:0] rdata
);

    logic [DATA_WID-1:0] mem [0:(1 << ADDR_WID) - 1];

    // Array write and registered read; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/scratchpad_mem_server.sv
// Memory-side responder: services single-word kernel reads/writes from on-chip RAM.
// Latency: read_ready at t+READ_LAT+1, write_ready at t+WRITE_LAT+1 after the enable.
// Backpressure: none; requests arriving while busy are dropped and flag err.
module scratchpad_mem_server
    import scratchpad_mem_pkg::*;
#(
    parameter int unsigned          ADDR_WID  = 13,
    parameter int unsigned          DATA_WID  = 32,
    parameter logic [63:0]          BASE_ADDR = 64'h0,
    parameter int unsigned          READ_LAT  = 2,
    parameter int unsigned          WRITE_LAT = 1,
    parameter logic [DATA_WID-1:0]  ERR_DATA  = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read_enable,
    input  logic [63:0]         read_addr,
    input  logic [63:0]         read_size,
    input  logic                finish_read,
    input  logic                write_enable,
    input  logic [63:0]         write_addr,
    input  logic [63:0]         write_size,
    input  logic [DATA_WID-1:0] write_data,
    input  logic                finish_write,
    output logic [63:0]         read_ready,
    output logic [DATA_WID-1:0] read_data,
    output logic [63:0]         write_ready,
    input  logic                init_we,
    input  logic [ADDR_WID-1:0] init_addr,
    input  logic [DATA_WID-1:0] init_data,
    output logic                busy,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count,
    output logic                err
);

    localparam logic [LAT_WID-1:0] RD_LAT_INIT = LAT_WID'(READ_LAT - 1);
    localparam logic [LAT_WID-1:0] WR_LAT_INIT = LAT_WID'(WRITE_LAT - 1);

    spm_state_t          state, state_n;
    logic [LAT_WID-1:0]  lat_cnt, lat_n;
    logic [ADDR_WID-1:0] rd_idx, rd_idx_n, wr_idx, wr_idx_n;
    logic                rd_oow, rd_oow_n, wr_oow, wr_oow_n;
    logic [DATA_WID-1:0] wr_word, wr_word_n;
    logic                wr_pend, wr_pend_n;
    logic [DATA_WID-1:0] data_hold, data_hold_n;
    logic [31:0]         rd_count_n, wr_count_n;
    logic                err_n;

    logic                ram_we;
    logic [ADDR_WID-1:0] ram_addr;
    logic [DATA_WID-1:0] ram_wdata, ram_rdata;
    logic [DATA_WID-1:0] resp_word;

    // Burst-end hints carry no meaning for a single-word responder.
    logic unused_hints;
    assign unused_hints = finish_read ^ finish_write;

    // Window decode: offset from the base, must be word aligned and inside the array.
    logic [63:0]         rd_off, wr_off;
    logic                rd_oow_c, wr_oow_c;
    logic                rd_bad_c, wr_bad_c;
    assign rd_off   = read_addr - BASE_ADDR;
    assign wr_off   = write_addr - BASE_ADDR;
    assign rd_oow_c = (rd_off[1:0] != 2'b00) || (rd_off[63:ADDR_WID+2] != '0);
    assign wr_oow_c = (wr_off[1:0] != 2'b00) || (wr_off[63:ADDR_WID+2] != '0);
    assign rd_bad_c = rd_oow_c || (read_size != WORD_BYTES);
    assign wr_bad_c = wr_oow_c || (write_size != WORD_BYTES);

    assign resp_word   = rd_oow ? ERR_DATA : ram_rdata;
    assign read_data   = (state == ST_RD_RESP) ? resp_word : data_hold;
    assign read_ready  = (state == ST_RD_RESP) ? RDY_ON : RDY_OFF;
    assign write_ready = (state == ST_WR_RESP) ? RDY_ON : RDY_OFF;
    assign busy        = (state != ST_IDLE);

    spm_word_ram #(
        .ADDR_WID (ADDR_WID),
        .DATA_WID (DATA_WID)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Next-state, request capture, counters and the RAM port mux.
    always_comb begin
        state_n     = state;
        lat_n       = lat_cnt;
        rd_idx_n    = rd_idx;
        rd_oow_n    = rd_oow;
        wr_idx_n    = wr_idx;
        wr_oow_n    = wr_oow;
        wr_word_n   = wr_word;
        wr_pend_n   = wr_pend;
        data_hold_n = data_hold;
        rd_count_n  = rd_count;
        wr_count_n  = wr_count;
        err_n       = err;
        ram_we      = 1'b0;
        ram_addr    = rd_idx;
        ram_wdata   = wr_word;

        // Any request or preload while a transfer is in flight is dropped.
        if ((state != ST_IDLE) && (read_enable || write_enable || init_we)) begin
            err_n = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (read_enable) begin
                    state_n  = ST_RD_WAIT;
                    lat_n    = RD_LAT_INIT;
                    rd_idx_n = rd_off[ADDR_WID+1:2];
                    rd_oow_n = rd_oow_c;
                    if (rd_bad_c) err_n = 1'b1;
                    // A simultaneous write parks in the pending slot behind the read.
                    if (write_enable) begin
                        wr_pend_n = 1'b1;
                        wr_idx_n  = wr_off[ADDR_WID+1:2];
                        wr_oow_n  = wr_oow_c;
                        wr_word_n = write_data;
                        if (wr_bad_c) err_n = 1'b1;
                    end
                end else if (write_enable) begin
                    state_n   = ST_WR_WAIT;
                    lat_n     = WR_LAT_INIT;
                    wr_idx_n  = wr_off[ADDR_WID+1:2];
                    wr_oow_n  = wr_oow_c;
                    wr_word_n = write_data;
                    if (wr_bad_c) err_n = 1'b1;
                end else if (init_we) begin
                    ram_we    = 1'b1;
                    ram_addr  = init_addr;
                    ram_wdata = init_data;
                end
            end
            ST_RD_WAIT: begin
                // RAM address is rd_idx here, so data is ready on entry to RD_RESP.
                if (lat_cnt == '0) state_n = ST_RD_RESP;
                else               lat_n   = lat_cnt - 1'b1;
            end
            ST_RD_RESP: begin
                data_hold_n = resp_word;
                rd_count_n  = (rd_count == '1) ? rd_count : rd_count + 32'd1;
                if (wr_pend) begin
                    state_n   = ST_WR_WAIT;
                    lat_n     = WR_LAT_INIT;
                    wr_pend_n = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (lat_cnt == '0) state_n = ST_WR_RESP;
                else               lat_n   = lat_cnt - 1'b1;
            end
            ST_WR_RESP: begin
                // Out-of-window writes still complete but never touch the array.
                ram_we     = !wr_oow;
                ram_addr   = wr_idx;
                wr_count_n = (wr_count == '1) ? wr_count : wr_count + 32'd1;
                state_n    = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            lat_cnt   <= '0;
            rd_idx    <= '0;
            rd_oow    <= 1'b0;
            wr_idx    <= '0;
            wr_oow    <= 1'b0;
            wr_word   <= '0;
            wr_pend   <= 1'b0;
            data_hold <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            lat_cnt   <= lat_n;
            rd_idx    <= rd_idx_n;
            rd_oow    <= rd_oow_n;
            wr_idx    <= wr_idx_n;
            wr_oow    <= wr_oow_n;
            wr_word   <= wr_word_n;
            wr_pend   <= wr_pend_n;
            data_hold <= data_hold_n;
            rd_count  <= rd_count_n;
            wr_count  <= wr_count_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_scratchpad_mem_server.sv
// Self-checking bench for scratchpad_mem_server: vector table, corner sequences, random traffic.
// Latency: checks ready pulses at t+READ_LAT+1 / t+WRITE_LAT+1 against a word-level model.
// Backpressure: issues back-to-back requests immediately after each response.
module tb_scratchpad_mem_server;

    localparam int          AW    = 13;
    localparam int          DEPTH = 1 << AW;
    localparam logic [63:0] BASE  = 64'h0000_0001_0000_0000;
    localparam int          RL    = 2;
    localparam int          WL    = 1;
    localparam logic [31:0] ERRD  = 32'hDEADBEEF;

    logic          clk, reset;
    logic          read_enable, finish_read, write_enable, finish_write, init_we;
    logic [63:0]   read_addr, read_size, write_addr, write_size;
    logic [31:0]   write_data, init_data;
    logic [AW-1:0] init_addr;
    logic [63:0]   read_ready, write_ready;
    logic [31:0]   read_data, rd_count, wr_count;
    logic          busy, err;

    scratchpad_mem_server #(
        .ADDR_WID (AW), .DATA_WID (32), .BASE_ADDR (BASE),
        .READ_LAT (RL), .WRITE_LAT (WL), .ERR_DATA (ERRD)
    ) dut (
        .clk (clk), .reset (reset),
        .read_enable (read_enable), .read_addr (read_addr), .read_size (read_size),
        .finish_read (finish_read),
        .write_enable (write_enable), .write_addr (write_addr), .write_size (write_size),
        .write_data (write_data), .finish_write (finish_write),
        .read_ready (read_ready), .read_data (read_data), .write_ready (write_ready),
        .init_we (init_we), .init_addr (init_addr), .init_data (init_data),
        .busy (busy), .rd_count (rd_count), .wr_count (wr_count), .err (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word array, counters, sticky error, last read value.
    logic [31:0] mem_m [DEPTH];
    int          m_rd, m_wr;
    logic        m_err;
    logic [31:0] m_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit out_of_window(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        return (off % 64'd4 != 64'd0) || (off / 64'd4 >= 64'(DEPTH));
    endfunction

    function automatic logic [31:0] exp_read(input logic [63:0] a);
        if (out_of_window(a)) return ERRD;
        return mem_m[int'((a - BASE) / 64'd4)];
    endfunction

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return BASE + 64'(DEPTH * 4) + 64'(4 * $urandom_range(0, 7));
        if (r == 1) return BASE + 64'(4 * $urandom_range(0, 63)) + 64'($urandom_range(1, 3));
        if (r == 2) return BASE - 64'd4;
        return BASE + 64'(4 * $urandom_range(0, 63));
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rrdy"}, read_ready, 64'd0);
        check({tag, "_wrdy"}, write_ready, 64'd0);
        check({tag, "_rdata"}, read_data, 64'd0);
        check({tag, "_busy"}, busy, 64'd0);
        check({tag, "_rdcnt"}, rd_count, 64'd0);
        check({tag, "_wrcnt"}, wr_count, 64'd0);
        check({tag, "_err"}, err, 64'd0);
    endtask

    task automatic model_reset();
        m_rd = 0; m_wr = 0; m_err = 1'b0; m_last = 32'd0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        reset = 1'b0;
        read_enable = 0; write_enable = 0; init_we = 0;
        @(negedge clk);
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic do_init(input int idx, input logic [31:0] d);
        @(posedge clk); #1;
        init_we = 1'b1; init_addr = AW'(idx); init_data = d;
        @(posedge clk); #1;
        init_we = 1'b0;
        mem_m[idx] = d;
    endtask

    // One transaction: drive for one cycle, then check every cycle up to the last response.
    task automatic issue(input logic re, input logic [63:0] ra, input logic [63:0] rs,
                         input logic we, input logic [63:0] wa, input logic [63:0] ws,
                         input logic [31:0] wd, output logic [31:0] got);
        int          k_rd, k_wr, k_last;
        logic [31:0] exp_rd;
        k_rd   = re ? RL + 1 : -1;
        k_wr   = we ? (re ? RL + 1 + WL + 1 : WL + 1) : -1;
        k_last = (k_wr > k_rd) ? k_wr : k_rd;
        got    = 32'd0;
        @(posedge clk); #1;
        read_enable = re; read_addr = ra; read_size = rs;
        write_enable = we; write_addr = wa; write_size = ws; write_data = wd;
        @(negedge clk);
        check("pre_busy", busy, 64'd0);
        check("pre_err", err, 64'(m_err));
        check("pre_rdcnt", rd_count, 64'(m_rd));
        check("pre_wrcnt", wr_count, 64'(m_wr));
        check("pre_rhold", read_data, 64'(m_last));
        check("pre_rrdy", read_ready, 64'd0);
        exp_rd = re ? exp_read(ra) : 32'd0;
        if (re && (out_of_window(ra) || rs != 64'd4)) m_err = 1'b1;
        if (we && (out_of_window(wa) || ws != 64'd4)) m_err = 1'b1;
        @(posedge clk); #1;
        read_enable = 1'b0; write_enable = 1'b0;
        for (int k = 1; k <= k_last; k++) begin
            @(negedge clk);
            check("rrdy_timing", read_ready, (k == k_rd) ? 64'd1 : 64'd0);
            check("wrdy_timing", write_ready, (k == k_wr) ? 64'd1 : 64'd0);
            check("busy_inflight", busy, 64'd1);
            if (k == k_rd) begin
                check("rdata", read_data, 64'(exp_rd));
                got = read_data;
            end
        end
        if (re) begin m_rd++; m_last = exp_rd; end
        if (we) begin
            m_wr++;
            if (!out_of_window(wa)) mem_m[int'((wa - BASE) / 64'd4)] = wd;
        end
    endtask

    typedef struct {
        logic        re;
        logic [63:0] ra;
        logic        we;
        logic [63:0] wa;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] got;
    int          pulses, pk;

    initial begin
        reset = 1'b0;
        read_enable = 0; write_enable = 0; init_we = 0;
        finish_read = 0; finish_write = 0;
        read_addr = 0; write_addr = 0; read_size = 64'd4; write_size = 64'd4;
        write_data = 0; init_addr = 0; init_data = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;

        for (int i = 0; i < 64; i++) do_init(i, $urandom);
        do_init(5, 32'h1234);
        do_init(0, 32'h1111);
        check("init_no_rdcnt", rd_count, 64'd0);
        check("init_no_wrcnt", wr_count, 64'd0);

        vecs[0] = '{1'b1, BASE + 64'd20, 1'b0, 64'd0, 32'd0, 32'h1234, 1'b0};
        vecs[1] = '{1'b0, 64'd0, 1'b1, BASE + 64'd8, 32'hA5A5, 32'd0, 1'b0};
        vecs[2] = '{1'b1, BASE + 64'd8, 1'b0, 64'd0, 32'd0, 32'hA5A5, 1'b0};
        vecs[3] = '{1'b1, BASE, 1'b1, BASE + 64'd4, 32'd7, 32'h1111, 1'b0};
        vecs[4] = '{1'b1, BASE + 64'd4, 1'b0, 64'd0, 32'd0, 32'd7, 1'b0};
        vecs[5] = '{1'b1, BASE + 64'(DEPTH * 4), 1'b0, 64'd0, 32'd0, ERRD, 1'b1};
        vecs[6] = '{1'b0, 64'd0, 1'b1, BASE + 64'd2, 32'h99, 32'd0, 1'b1};
        vecs[7] = '{1'b1, BASE, 1'b0, 64'd0, 32'd0, 32'h1111, 1'b1};
        vecs[8] = '{1'b1, BASE + 64'd8, 1'b0, 64'd0, 32'd0, 32'hA5A5, 1'b1};
        for (int v = 0; v < 9; v++) begin
            issue(vecs[v].re, vecs[v].ra, 64'd4, vecs[v].we, vecs[v].wa, 64'd4, vecs[v].wd, got);
            if (vecs[v].re) check($sformatf("vec%0d_rdata", v), got, 64'(vecs[v].exp_rd));
            check($sformatf("vec%0d_err", v), err, 64'(vecs[v].exp_err));
        end

        // Second read while the first waits: dropped, one pulse only, err set.
        reset_dut();
        @(posedge clk); #1;
        read_enable = 1'b1; read_addr = BASE + 64'd20; read_size = 64'd4;
        pulses = 0; pk = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            read_enable = (k == 1); read_addr = BASE;
            @(negedge clk);
            if (read_ready != 64'd0) begin
                pulses++; pk = k;
                check("dup_rrdy_val", read_ready, 64'd1);
                check("dup_rdata", read_data, 64'(mem_m[5]));
            end
        end
        check("dup_pulses", 64'(pulses), 64'd1);
        check("dup_pulse_cycle", 64'(pk), 64'(RL + 1));
        check("dup_err", err, 64'd1);
        check("dup_rdcnt", rd_count, 64'd1);
        m_rd = 1; m_err = 1'b1; m_last = mem_m[5];

        // Preload attempted while busy: ignored and flagged.
        reset_dut();
        @(posedge clk); #1;
        read_enable = 1'b1; read_addr = BASE + 64'd20;
        @(posedge clk); #1;
        read_enable = 1'b0;
        init_we = 1'b1; init_addr = AW'(5); init_data = 32'h0BAD;
        @(posedge clk); #1;
        init_we = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_init_err", err, 64'd1);
        m_rd = 1; m_err = 1'b1; m_last = mem_m[5];
        issue(1'b1, BASE + 64'd20, 64'd4, 1'b0, 64'd0, 64'd4, 32'd0, got);
        check("busy_init_kept", got, 64'(mem_m[5]));

        // Reset during WR_WAIT: write abandoned, no pulse, word unchanged.
        reset_dut();
        @(posedge clk); #1;
        write_enable = 1'b1; write_addr = BASE + 64'd40; write_data = 32'hCAFE; write_size = 64'd4;
        @(posedge clk); #1;
        write_enable = 1'b0;
        check("wrwait_busy", busy, 64'd1);
        #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_reset_outputs("midrst");
        end
        reset = 1'b1;
        model_reset();
        issue(1'b1, BASE + 64'd40, 64'd4, 1'b0, 64'd0, 64'd4, 32'd0, got);
        check("midrst_word_kept", got, 64'(mem_m[10]));

        // Size error on an otherwise legal read.
        issue(1'b1, BASE + 64'd12, 64'd8, 1'b0, 64'd0, 64'd4, 32'd0, got);
        check("size_err", err, 64'd1);

        // Randomized traffic against the model.
        reset_dut();
        for (int n = 0; n < 200; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            issue(kind != 1, rand_addr(), ($urandom_range(0, 9) == 0) ? 64'd8 : 64'd4,
                  kind != 0, rand_addr(), ($urandom_range(0, 9) == 0) ? 64'd8 : 64'd4,
                  $urandom, got);
            if ($urandom_range(0, 4) == 0) do_init($urandom_range(0, 63), $urandom);
        end

        // Trailing idle: no stray pulses, counters settled.
        repeat (4) begin
            @(negedge clk);
            check("idle_rrdy", read_ready, 64'd0);
            check("idle_wrdy", write_ready, 64'd0);
            check("idle_busy", busy, 64'd0);
        end
        check("final_rdcnt", rd_count, 64'(m_rd));
        check("final_wrcnt", wr_count, 64'(m_wr));
        check("final_err", err, 64'(m_err));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
